imem_load_ctrl: RTL and testbench

Controller that owns access to the instruction BRAM and sequences the fetch stage around it. In normal operation it passes the pipeline's stall, flush and branch controls straight through to the fetch stage. On a host load request it drains and freezes fetch, streams 32-bit words from a loader interface into the instruction memory write port, then restarts fetch at the boot PC with a redirect. It sits between the hazard/branch logic, the fetch stage and the shared instruction memory.

---
 rtl/imem_load_ctrl.sv | 170 +++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: owns the instruction BRAM write port and sequences fetch
// around a host program load (drain, stream words, restart at boot PC).
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   load_req_i          level request from host to load a program
//   ld_valid_i/ready_o  loader beat handshake
//   ld_addr_i/data_i    beat byte address (word aligned) and instruction word
//   ld_last_i           final beat, qualified by the handshake
//   core_*_i            stall/flush/branch controls from hazard/branch logic
//   if_*_o              controls to fetch (passthrough in RUN, overridden otherwise)
//   mem_we/addr/wdata_o registered write port to the four byte BRAMs
//   busy_o              not in RUN
//   err_o               sticky error for the current/last load
//   words_o             words written in the current/last load
module imem_load_ctrl #(
    parameter int unsigned ADDR_W       = 11,
    parameter logic [31:0] BOOT_PC      = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_req_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [31:0]       ld_addr_i,
    input  logic [31:0]       ld_data_i,
    input  logic              ld_last_i,
    input  logic              core_stall_i,
    input  logic              core_flush_i,
    input  logic              core_bj_i,
    input  logic [31:0]       core_pc_bj_i,
    output logic              if_stall_o,
    output logic              if_flush_o,
    output logic              if_take_b_j_o,
    output logic [31:0]       if_pc_b_j_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [ADDR_W-3:0] words_o
);

    localparam int unsigned CNT_W =
        (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_LOAD,
        S_RESTART
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_err;
    logic [ADDR_W-3:0] r_words;

    logic w_hs;
    logic w_bad;

    assign w_hs  = (r_state == S_LOAD) && ld_valid_i;
    // Out-of-range or misaligned beats are consumed but never written.
    assign w_bad = (|ld_addr_i[31:ADDR_W]) || (|ld_addr_i[1:0]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        if_stall_o    = core_stall_i;
        if_flush_o    = core_flush_i;
        if_take_b_j_o = core_bj_i;
        if_pc_b_j_o   = core_pc_bj_i;
        ld_ready_o    = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (load_req_i) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Fetch prioritises flush/branch over stall, so mask them.
                if_stall_o    = 1'b1;
                if_flush_o    = 1'b0;
                if_take_b_j_o = 1'b0;
                if (!load_req_i) begin
                    w_state_nxt = S_RESTART;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if_stall_o    = 1'b1;
                if_flush_o    = 1'b0;
                if_take_b_j_o = 1'b0;
                ld_ready_o    = 1'b1;
                if (w_hs) begin
                    if (ld_last_i) begin
                        w_state_nxt = S_RESTART;
                    end
                end else if (!load_req_i) begin
                    w_state_nxt = S_RESTART;
                end
            end
            S_RESTART: begin
                if_stall_o    = 1'b0;
                if_flush_o    = 1'b0;
                if_take_b_j_o = 1'b1;
                if_pc_b_j_o   = BOOT_PC;
                w_state_nxt   = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_we    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_words <= '0;
        end else begin
            r_we <= '0;
            if (r_state == S_RUN && load_req_i) begin
                r_cnt   <= CNT_W'(DRAIN_CYCLES - 1);
                r_err   <= 1'b0;
                r_words <= '0;
            end else if (r_state == S_DRAIN && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_hs) begin
                r_addr <= ld_addr_i[ADDR_W-1:0];
                r_data <= ld_data_i;
                if (w_bad) begin
                    r_err <= 1'b1;
                end else begin
                    r_we <= 4'hF;
                    if (r_words != '1) begin
                        r_words <= r_words + 1'b1;
                    end
                end
            end else if (r_state == S_LOAD && !load_req_i) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_data;
    assign err_o       = r_err;
    assign words_o     = r_words;
    assign busy_o      = (r_state != S_RUN);

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: randomized loads against a cycle-level
// reference of the load protocol.
module tb_imem_load_ctrl;

    localparam int          AW = 11;
    localparam int          DC = 2;
    localparam logic [31:0] BP = 32'h0000_0000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          load_req_i;
    logic          ld_valid_i;
    logic          ld_ready_o;
    logic [31:0]   ld_addr_i;
    logic [31:0]   ld_data_i;
    logic          ld_last_i;
    logic          core_stall_i;
    logic          core_flush_i;
    logic          core_bj_i;
    logic [31:0]   core_pc_bj_i;
    logic          if_stall_o;
    logic          if_flush_o;
    logic          if_take_b_j_o;
    logic [31:0]   if_pc_b_j_o;
    logic [3:0]    mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          busy_o;
    logic          err_o;
    logic [AW-3:0] words_o;

    int checks = 0;
    int errors = 0;
    bit force_hi = 1'b0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    always #5 clk_i = ~clk_i;

    imem_load_ctrl #(
        .ADDR_W(AW), .BOOT_PC(BP), .DRAIN_CYCLES(DC)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .load_req_i(load_req_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
        .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
        .core_stall_i(core_stall_i), .core_flush_i(core_flush_i),
        .core_bj_i(core_bj_i), .core_pc_bj_i(core_pc_bj_i),
        .if_stall_o(if_stall_o), .if_flush_o(if_flush_o),
        .if_take_b_j_o(if_take_b_j_o), .if_pc_b_j_o(if_pc_b_j_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .busy_o(busy_o), .err_o(err_o),
        .words_o(words_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_core();
        core_stall_i = force_hi ? 1'b1 : 1'($urandom_range(1));
        core_flush_i = force_hi ? 1'b1 : 1'($urandom_range(1));
        core_bj_i    = force_hi ? 1'b1 : 1'($urandom_range(1));
        core_pc_bj_i = $urandom;
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a >= 32'(1 << AW)) || (a % 4 != 0);
    endfunction

    task automatic test_reset();
        rst_i = 1'b1; load_req_i = 0; ld_valid_i = 0; ld_last_i = 0;
        ld_addr_i = 0; ld_data_i = 0;
        core_stall_i = 0; core_flush_i = 0; core_bj_i = 1;
        core_pc_bj_i = 32'h40;
        #3;
        checks++;
        if ({mem_we_o, mem_addr_o, mem_wdata_o, err_o, words_o} !== '0) begin
            errors++;
            $display("FAIL reset_regs we=%h a=%h d=%h e=%b w=%0d want 0",
                     mem_we_o, mem_addr_o, mem_wdata_o, err_o, words_o);
        end
        checks++;
        if (if_take_b_j_o !== 1'b1 || if_pc_b_j_o !== 32'h40 ||
            ld_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_pass bj=%b pc=%h rdy=%b busy=%b want 1 40 0 0",
                     if_take_b_j_o, if_pc_b_j_o, ld_ready_o, busy_o);
        end
        tick;
        rst_i = 1'b0;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 8; i++) begin
            tick;
            rand_core();
            #1;
            checks++;
            if ({if_stall_o, if_flush_o, if_take_b_j_o, if_pc_b_j_o} !==
                {core_stall_i, core_flush_i, core_bj_i, core_pc_bj_i} ||
                ld_ready_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL run_pass got %b%b%b %h rdy=%b busy=%b want %b%b%b %h 0 0",
                         if_stall_o, if_flush_o, if_take_b_j_o, if_pc_b_j_o,
                         ld_ready_o, busy_o, core_stall_i, core_flush_i,
                         core_bj_i, core_pc_bj_i);
            end
        end
    endtask

    // mode 0: last on final beat; 1: drop request after beats;
    // 2: drop request together with the final (non-last) beat.
    task automatic run_load(input int n, input int mode, input int gap);
        logic [AW-3:0] ew;
        bit            ee;
        bit            pend;
        bit            done;
        logic [31:0]   pa;
        logic [31:0]   pd;
        int            idx;
        int            guard;
        ew = '0; ee = 0; pend = 0; done = 0; idx = 0; guard = 0;
        pa = 0; pd = 0;
        tick;
        load_req_i = 1'b1;
        rand_core();
        #1;
        checks++;
        if (if_take_b_j_o !== core_bj_i || if_flush_o !== core_flush_i ||
            ld_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL req_cycle bj=%b fl=%b rdy=%b busy=%b want %b %b 0 0",
                     if_take_b_j_o, if_flush_o, ld_ready_o, busy_o,
                     core_bj_i, core_flush_i);
        end
        for (int d = 0; d < DC; d++) begin
            tick;
            rand_core();
            ld_valid_i = 1'($urandom_range(1));
            ld_addr_i  = $urandom_range(63) * 4;
            ld_data_i  = $urandom;
            ld_last_i  = 1'($urandom_range(1));
            #1;
            checks++;
            if ({if_stall_o, if_flush_o, if_take_b_j_o, ld_ready_o, busy_o}
                !== 5'b10001) begin
                errors++;
                $display("FAIL drain st/fl/bj/rdy/busy=%b%b%b%b%b want 10001",
                         if_stall_o, if_flush_o, if_take_b_j_o, ld_ready_o,
                         busy_o);
            end
        end
        while (!done && guard < 400) begin
            tick;
            guard++;
            checks++;
            if (mem_we_o !== (pend ? 4'hF : 4'h0) ||
                (pend && (mem_addr_o !== pa[AW-1:0] || mem_wdata_o !== pd))) begin
                errors++;
                $display("FAIL load_write we=%h a=%h d=%h want we=%h a=%h d=%h",
                         mem_we_o, mem_addr_o, mem_wdata_o,
                         pend ? 4'hF : 4'h0, pa[AW-1:0], pd);
            end
            checks++;
            if (words_o !== ew || err_o !== ee) begin
                errors++;
                $display("FAIL load_stat words=%0d err=%b want %0d %b",
                         words_o, err_o, ew, ee);
            end
            rand_core();
            ld_valid_i = 1'b0;
            ld_last_i  = 1'($urandom_range(1));
            ld_addr_i  = $urandom;
            ld_data_i  = $urandom;
            if (idx < n && $urandom_range(99) >= gap) begin
                ld_valid_i = 1'b1;
                ld_addr_i  = q_addr[idx];
                ld_data_i  = q_data[idx];
                ld_last_i  = (mode == 0 && idx == n - 1);
                if (mode == 2 && idx == n - 1) load_req_i = 1'b0;
            end
            if (mode == 1 && idx >= n) load_req_i = 1'b0;
            #1;
            checks++;
            if ({if_stall_o, if_flush_o, if_take_b_j_o, ld_ready_o, busy_o}
                !== 5'b10011) begin
                errors++;
                $display("FAIL load_ctl st/fl/bj/rdy/busy=%b%b%b%b%b want 10011",
                         if_stall_o, if_flush_o, if_take_b_j_o, ld_ready_o,
                         busy_o);
            end
            pend = 0;
            if (ld_valid_i) begin
                pa = ld_addr_i;
                pd = ld_data_i;
                if (bad_addr(pa)) begin
                    ee = 1;
                end else begin
                    pend = 1;
                    if (ew != '1) ew = ew + 1'b1;
                end
                if (ld_last_i) done = 1;
                idx++;
            end else if (!load_req_i) begin
                ee = 1;
                done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL load_timeout beats=%0d want load to end", idx);
        end
        tick;
        checks++;
        if (mem_we_o !== (pend ? 4'hF : 4'h0) ||
            (pend && (mem_addr_o !== pa[AW-1:0] || mem_wdata_o !== pd))) begin
            errors++;
            $display("FAIL last_write we=%h a=%h d=%h want we=%h a=%h d=%h",
                     mem_we_o, mem_addr_o, mem_wdata_o,
                     pend ? 4'hF : 4'h0, pa[AW-1:0], pd);
        end
        load_req_i = 1'b0;
        ld_valid_i = 1'b0;
        rand_core();
        #1;
        checks++;
        if ({if_stall_o, if_flush_o, if_take_b_j_o, ld_ready_o, busy_o}
            !== 5'b00101 || if_pc_b_j_o !== BP) begin
            errors++;
            $display("FAIL restart st/fl/bj/rdy/busy=%b%b%b%b%b pc=%h want 00101 %h",
                     if_stall_o, if_flush_o, if_take_b_j_o, ld_ready_o,
                     busy_o, if_pc_b_j_o, BP);
        end
        tick;
        rand_core();
        #1;
        checks++;
        if (busy_o !== 1'b0 || mem_we_o !== 4'h0 || words_o !== ew ||
            err_o !== ee || if_take_b_j_o !== core_bj_i ||
            if_pc_b_j_o !== core_pc_bj_i) begin
            errors++;
            $display("FAIL after_load busy=%b we=%h words=%0d err=%b want 0 0 %0d %b",
                     busy_o, mem_we_o, words_o, err_o, ew, ee);
        end
    endtask

    task automatic test_normal_load();
        q_addr = '{32'h0, 32'h4};
        q_data = '{32'h0050_0093, 32'h0010_8113};
        run_load(2, 0, 0);
    endtask

    task automatic test_masking();
        force_hi = 1'b1;
        q_addr = '{32'h100, 32'h104, 32'h108};
        q_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        run_load(3, 0, 40);
        force_hi = 1'b0;
    endtask

    task automatic test_bad_beats();
        q_addr = '{32'h800, 32'h6, 32'h8};
        q_data = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678};
        run_load(3, 0, 0);
    endtask

    task automatic test_abort();
        q_addr = '{32'h10};
        q_data = '{32'hA5A5_5A5A};
        run_load(1, 1, 0);
        q_addr = '{32'h20, 32'h24};
        q_data = '{32'h0BAD_F00D, 32'h7777_0001};
        run_load(2, 2, 0);
    endtask

    task automatic test_random_loads();
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(8, 1);
            q_addr.delete();
            q_data.delete();
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(7) == 0) q_addr.push_back($urandom);
                else q_addr.push_back($urandom_range(511) * 4);
                q_data.push_back($urandom);
            end
            run_load(n, $urandom_range(2), 30);
        end
    endtask

    task automatic test_drain_abort();
        tick;
        load_req_i = 1'b1;
        tick;
        load_req_i = 1'b0;
        rand_core();
        #1;
        checks++;
        if (if_stall_o !== 1'b1 || busy_o !== 1'b1 || ld_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_abort st=%b busy=%b rdy=%b want 1 1 0",
                     if_stall_o, busy_o, ld_ready_o);
        end
        tick;
        #1;
        checks++;
        if (if_take_b_j_o !== 1'b1 || if_pc_b_j_o !== BP) begin
            errors++;
            $display("FAIL drain_abort_redir bj=%b pc=%h want 1 %h",
                     if_take_b_j_o, if_pc_b_j_o, BP);
        end
        tick;
        #1;
        checks++;
        if (busy_o !== 1'b0 || words_o !== '0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_abort_end busy=%b words=%0d err=%b want 0 0 0",
                     busy_o, words_o, err_o);
        end
    endtask

    task automatic test_async_reset();
        tick;
        load_req_i = 1'b1;
        tick;
        tick;
        tick;
        checks++;
        if (ld_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ar_ready got %b want 1", ld_ready_o);
        end
        ld_valid_i = 1'b1;
        ld_addr_i  = 32'h20;
        ld_data_i  = 32'h1357_9BDF;
        ld_last_i  = 1'b0;
        tick;
        ld_valid_i = 1'b0;
        checks++;
        if (mem_we_o !== 4'hF || mem_addr_o !== 11'h20) begin
            errors++;
            $display("FAIL ar_pending we=%h a=%h want f 20", mem_we_o, mem_addr_o);
        end
        #2;
        rst_i = 1'b1;
        rand_core();
        #1;
        checks++;
        if (mem_we_o !== 4'h0 || busy_o !== 1'b0 || ld_ready_o !== 1'b0 ||
            words_o !== '0 || err_o !== 1'b0 || mem_addr_o !== '0 ||
            mem_wdata_o !== '0) begin
            errors++;
            $display("FAIL ar_reset we=%h busy=%b rdy=%b w=%0d e=%b want all 0",
                     mem_we_o, busy_o, ld_ready_o, words_o, err_o);
        end
        load_req_i = 1'b0;
        tick;
        rst_i = 1'b0;
        tick;
        rand_core();
        #1;
        checks++;
        if ({if_stall_o, if_flush_o, if_take_b_j_o, if_pc_b_j_o} !==
            {core_stall_i, core_flush_i, core_bj_i, core_pc_bj_i} ||
            busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ar_resume got %b%b%b %h busy=%b want %b%b%b %h 0",
                     if_stall_o, if_flush_o, if_take_b_j_o, if_pc_b_j_o,
                     busy_o, core_stall_i, core_flush_i, core_bj_i,
                     core_pc_bj_i);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_normal_load();
        test_masking();
        test_bad_beats();
        test_abort();
        test_drain_abort();
        test_random_loads();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
